// File: rtl/fir_mac_sched_pkg.sv
// fir_pkg: shared definitions for the time-multiplexed FIR controller.
//   - FSM state encoding (IDLE, MAC, OUT)
//   - default sample/coefficient width, tap count, accumulator width
//   - tap-index width used by the coefficient address bus
package fir_pkg;

   localparam int DATA_W = 8;
   localparam int NTAPS  = 4;
   localparam int ACC_W  = 2 * DATA_W + 2;
   localparam int TAP_W  = $clog2(NTAPS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } fir_state_e;

endpackage

// File: rtl/fir_mac_sched_if.sv
// fir_mac_sched_if: sample-in / result-out handshakes plus the coefficient
// write bus of the FIR controller.
//   slave  : the controller side (fir_mac_sched)
//   master : the environment side (source, consumer, coefficient writer)
// Signals:
//   in_valid/in_data/in_ready     upstream sample handshake
//   out_valid/out_data/out_ready  downstream result handshake
//   coef_we/coef_addr/coef_data   coefficient write strobe, tap index, value
interface fir_mac_sched_if #(
   parameter int DATA_W = fir_pkg::DATA_W
);
   import fir_pkg::*;

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              coef_we;
   logic [TAP_W-1:0]  coef_addr;
   logic [DATA_W-1:0] coef_data;

   modport slave (
      input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
      input  in_ready, out_valid, out_data
   );

endinterface

// File: rtl/fir_mac_sched_mac_unit.sv
// fir_mac_unit: registered unsigned multiply-accumulate.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous accumulator clear
//   en          perform one MAC step this cycle
//   load        with en: acc <= a*b (first tap) instead of acc + a*b
//   a, b        DATA_W-bit unsigned operands
//   acc         ACC_W-bit accumulator
module fir_mac_unit #(
   parameter int DATA_W = fir_pkg::DATA_W,
   parameter int ACC_W  = 2 * DATA_W + 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic              load,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [ACC_W-1:0]  acc
);
   import fir_pkg::*;

   logic [2*DATA_W-1:0] prod;
   logic [ACC_W-1:0]    prod_ext;

   // Operands are widened before multiplying so the full product is kept.
   assign prod     = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
   assign prod_ext = {{(ACC_W-2*DATA_W){1'b0}}, prod};

   // Accumulator: the load select lets the first tap overwrite the previous
   // sample's sum, so no separate clear cycle is needed between samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= load ? prod_ext : (acc + prod_ext);
      end
   end

endmodule

// File: rtl/fir_mac_sched.sv
// fir_mac_sched: 4-tap unsigned FIR controller with one shared MAC.
// Owns the sample delay line and coefficient bank and walks the taps one per
// cycle through fir_mac_unit. A sample accepted at edge T produces out_valid
// at edge T+5; the result is held until the consumer takes it.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous flush of delay line and computation (coefs kept)
//   busy        FSM is not in IDLE
//   bus         fir_mac_sched_if.slave (sample in, result out, coef writes)
// Build option:
//   FIR_SAT_EN  when defined, the shifted sum is clamped to 2^DATA_W-1;
//               otherwise its low DATA_W bits are output (wrap).
module fir_mac_sched #(
   parameter int DATA_W    = fir_pkg::DATA_W,
   parameter int NTAPS     = fir_pkg::NTAPS,
   parameter int OUT_SHIFT = 0,
   parameter int COEF_RST  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   output logic             busy,
   fir_mac_sched_if.slave   bus
);
   import fir_pkg::*;

   localparam int AW = 2 * DATA_W + 2;
   localparam int KW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
   localparam logic [KW-1:0] LAST_TAP = KW'(NTAPS - 1);

   fir_state_e        state, state_nxt;
   logic [DATA_W-1:0] taps  [NTAPS];
   logic [DATA_W-1:0] coefs [NTAPS];
   logic [KW-1:0]     tap_cnt;
   logic [AW-1:0]     acc;
   logic [DATA_W-1:0] y_narrow;
   logic [DATA_W-1:0] out_data_q;
   logic              out_valid_q;
   logic              rst_done;
   logic              in_ready_c;
   logic              accept;
   logic              coef_wr;
   logic              mac_en;
   logic              mac_load;
   logic              out_load;

   // rst_done keeps in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_done <= 1'b0;
      end else begin
         rst_done <= 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: clr overrides every transition and returns to IDLE.
   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) state_nxt = MAC;
            MAC:     if (tap_cnt == LAST_TAP) state_nxt = OUT;
            OUT:     if (out_valid_q && bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // FSM outputs. Samples and coefficient writes are only taken in IDLE,
   // and a clr cycle blocks both. The result register is loaded once on
   // the first OUT cycle and then held.
   always_comb begin
      in_ready_c = (state == IDLE) && rst_done && !clr;
      accept     = in_ready_c && bus.in_valid;
      coef_wr    = (state == IDLE) && bus.coef_we && !clr;
      mac_en     = (state == MAC) && !clr;
      mac_load   = (tap_cnt == '0);
      out_load   = (state == OUT) && !out_valid_q && !clr;
      busy       = (state != IDLE);
   end

   // Tap counter runs 0..NTAPS-1 while in MAC and idles at zero elsewhere.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_cnt <= '0;
      end else if (clr || (state != MAC)) begin
         tap_cnt <= '0;
      end else begin
         tap_cnt <= tap_cnt + 1'b1;
      end
   end

   // Delay line: taps[0] is the newest sample x[n], taps[k] is x[n-k].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NTAPS; i++) taps[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < NTAPS; i++) taps[i] <= '0;
      end else if (accept) begin
         taps[0] <= bus.in_data;
         for (int i = 1; i < NTAPS; i++) taps[i] <= taps[i-1];
      end
   end

   // Coefficient bank. A write in the same cycle as a sample accept commits
   // at that edge, before the first MAC cycle reads it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NTAPS; i++) coefs[i] <= DATA_W'(COEF_RST);
      end else if (coef_wr) begin
         coefs[bus.coef_addr] <= bus.coef_data;
      end
   end

   fir_mac_unit #(
      .DATA_W (DATA_W),
      .ACC_W  (AW)
   ) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .en    (mac_en),
      .load  (mac_load),
      .a     (taps[tap_cnt]),
      .b     (coefs[tap_cnt]),
      .acc   (acc)
   );

   // Output narrowing of the shifted accumulator.
`ifdef FIR_SAT_EN
   localparam logic [AW-1:0] OUT_MAX = {{(AW-DATA_W){1'b0}}, {DATA_W{1'b1}}};
   logic [AW-1:0] acc_shift;
   assign acc_shift = acc >> OUT_SHIFT;
   assign y_narrow  = (acc_shift > OUT_MAX) ? OUT_MAX[DATA_W-1:0]
                                            : acc_shift[DATA_W-1:0];
`else
   assign y_narrow = DATA_W'(acc >> OUT_SHIFT);
`endif

   // Result register: loaded on entry to OUT, held through backpressure,
   // released by the consumer handshake or flushed by clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (clr) begin
         out_valid_q <= 1'b0;
      end else if (out_load) begin
         out_valid_q <= 1'b1;
         out_data_q  <= y_narrow;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

endmodule
